polaris_dbridge16: RTL

- Downstream neighbour of the CPU D master port.
- Takes one 64-bit-wide load/store request (address, size, signedness, write data) and executes it as 1, 2 or 4 sequential 16-bit beats on a narrow memory bus.
- Returns a single acknowledge with the assembled, sign- or zero-extended 64-bit read data.
- Lets the core run against 16-bit SRAM/ROM/I/O fabric without changing the core's sequencer.

---
 rtl/polaris_dbridge16.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/polaris_dbridge16.sv
// 64-bit CPU data port to 16-bit memory bus bridge: splits one load/store into 1, 2 or 4 beats.
// Optional beat watchdog with error acknowledge: define POLARIS_DBRIDGE_TIMEOUT_EN.
module polaris_dbridge16 #(
    parameter int ADR_W   = 64,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [ADR_W-1:0] dadr_i,
    input  logic [63:0]      ddat_i,
    output logic [63:0]      ddat_o,
    input  logic             dwe_i,
    input  logic             dcyc_i,
    input  logic             dstb_i,
    input  logic [1:0]       dsiz_i,
    input  logic             dsigned_i,
    output logic             dack_o,
    output logic             misalign_o,
    output logic             derr_o,
    output logic [ADR_W-1:0] madr_o,
    output logic [15:0]      mdat_o,
    input  logic [15:0]      mdat_i,
    output logic [1:0]       msel_o,
    output logic             mwe_o,
    output logic             mcyc_o,
    output logic             mstb_o,
    input  logic             mack_i
);

    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    state_t           state;
    logic [1:0]       siz_q;
    logic [1:0]       beat_q;
    logic             sgn_q;
    logic             lane_q;
    logic             we_q;
    logic [63:0]      wdat_q;
    logic [63:0]      rbuf_q;

    logic [ADR_W-1:0] align_mask;
    logic [ADR_W-1:0] base_w;
    logic             mis_w;
    logic [1:0]       last_w;
    logic [1:0]       beat_nxt;
    logic [7:0]       byte_w;
    logic [63:0]      rfull_w;
    logic [63:0]      rext_w;

`ifdef POLARIS_DBRIDGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;
`else
    assign derr_o = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        align_mask = ~((ADR_W'(1) << dsiz_i) - ADR_W'(1));
        mis_w      = |(dadr_i & ~align_mask);
        base_w     = dadr_i & align_mask & ~ADR_W'(1);
        last_w     = (siz_q == 2'd3) ? 2'd3 : (siz_q == 2'd2) ? 2'd1 : 2'd0;
        beat_nxt   = beat_q + 2'd1;
        byte_w     = lane_q ? mdat_i[15:8] : mdat_i[7:0];

        rfull_w                        = rbuf_q;
        rfull_w[{beat_q, 4'd0} +: 16]  = mdat_i;

        case (siz_q)
            2'd0:    rext_w = {{56{sgn_q & byte_w[7]}}, byte_w};
            2'd1:    rext_w = {{48{sgn_q & rfull_w[15]}}, rfull_w[15:0]};
            2'd2:    rext_w = {{32{sgn_q & rfull_w[31]}}, rfull_w[31:0]};
            default: rext_w = rfull_w;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            siz_q      <= '0;
            beat_q     <= '0;
            sgn_q      <= 1'b0;
            lane_q     <= 1'b0;
            we_q       <= 1'b0;
            wdat_q     <= '0;
            rbuf_q     <= '0;
            ddat_o     <= '0;
            dack_o     <= 1'b0;
            misalign_o <= 1'b0;
            madr_o     <= '0;
            mdat_o     <= '0;
            msel_o     <= '0;
            mwe_o      <= 1'b0;
            mcyc_o     <= 1'b0;
            mstb_o     <= 1'b0;
`ifdef POLARIS_DBRIDGE_TIMEOUT_EN
            derr_o     <= 1'b0;
            wait_cnt   <= '0;
`endif
        end else begin
            dack_o     <= 1'b0;
            misalign_o <= 1'b0;
            ddat_o     <= '0;
`ifdef POLARIS_DBRIDGE_TIMEOUT_EN
            derr_o     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (dcyc_i && dstb_i) begin
                        state      <= BEAT;
                        beat_q     <= '0;
                        siz_q      <= dsiz_i;
                        sgn_q      <= dsigned_i;
                        lane_q     <= dadr_i[0];
                        we_q       <= dwe_i;
                        wdat_q     <= ddat_i;
                        rbuf_q     <= '0;
                        mcyc_o     <= 1'b1;
                        mstb_o     <= 1'b1;
                        mwe_o      <= dwe_i;
                        madr_o     <= base_w;
                        misalign_o <= mis_w;
`ifdef POLARIS_DBRIDGE_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                        if (dsiz_i == 2'd0) begin
                            msel_o <= dadr_i[0] ? 2'b10 : 2'b01;
                            mdat_o <= {ddat_i[7:0], ddat_i[7:0]};
                        end else begin
                            msel_o <= 2'b11;
                            mdat_o <= ddat_i[15:0];
                        end
                    end
                end

                BEAT: begin
                    if (mack_i) begin
                        rbuf_q <= rfull_w;
`ifdef POLARIS_DBRIDGE_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        if (beat_q == last_w) begin
                            state  <= DONE;
                            mcyc_o <= 1'b0;
                            mstb_o <= 1'b0;
                            mwe_o  <= 1'b0;
                            msel_o <= '0;
                            dack_o <= 1'b1;
                            ddat_o <= we_q ? 64'd0 : rext_w;
                        end else begin
                            // Strobe stays up; only address and write lane advance.
                            beat_q <= beat_nxt;
                            madr_o <= madr_o + ADR_W'(2);
                            mdat_o <= wdat_q[{beat_nxt, 4'd0} +: 16];
                        end
                    end
`ifdef POLARIS_DBRIDGE_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state  <= DONE;
                        mcyc_o <= 1'b0;
                        mstb_o <= 1'b0;
                        mwe_o  <= 1'b0;
                        msel_o <= '0;
                        dack_o <= 1'b1;
                        derr_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
